// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: 2-flop input synchroniser, mid-bit sampling FSM, one-clk done pulse.
// Optional parity stage and parity_err output enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic            parity_err
`endif
);

   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] S_MID      = SW'(7);
   localparam logic [SW-1:0] S_LAST     = SW'(15);
   localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic parity_mismatch(input logic [DBIT-1:0] data,
                                            input logic pbit, input logic odd);
      return (^data) ^ pbit ^ odd;
   endfunction

   logic parity_bad_r;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
`endif

   state_t          state_r;
   logic            rx_meta_r;
   logic            rx_s;
   logic [SW-1:0]   s_r;
   logic [NW-1:0]   n_r;
   logic [DBIT-1:0] b_r;
   logic            stop_ok_r;
   logic            stop_bit_s;

   // With a 16-tick stop bit the sample and completion tick coincide, so bypass the captured copy.
   assign stop_bit_s = (s_r == S_LAST) ? rx_s : stop_ok_r;

   // Synchroniser, receive FSM, tick/bit counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_r    <= 1'b1;
         rx_s         <= 1'b1;
         state_r      <= IDLE;
         s_r          <= SW'(0);
         n_r          <= NW'(0);
         b_r          <= DBIT'(0);
         stop_ok_r    <= 1'b0;
         dout         <= DBIT'(0);
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad_r <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         rx_meta_r    <= rx;
         rx_s         <= rx_meta_r;
         rx_done_tick <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!rx_s) begin
                  state_r <= START;
                  s_r     <= SW'(0);
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_r == S_MID) begin
                     if (!rx_s) begin
                        state_r <= DATA;
                        s_r     <= SW'(0);
                        n_r     <= NW'(0);
                     end else begin
                        state_r <= IDLE;
                     end
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_r == S_LAST) begin
                     s_r <= SW'(0);
                     b_r <= {rx_s, b_r[DBIT-1:1]};
                     if (n_r == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_r <= PARITY;
`else
                        state_r <= STOP;
`endif
                     end else begin
                        n_r <= n_r + NW'(1);
                     end
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s_r == S_LAST) begin
                     parity_bad_r <= parity_mismatch(b_r, rx_s, PARITY_ODD);
                     s_r          <= SW'(0);
                     state_r      <= STOP;
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s_r == S_LAST) begin
                     stop_ok_r <= rx_s;
                  end
                  if (s_r == S_STOP_END) begin
                     dout         <= b_r;
                     frame_err    <= ~stop_bit_s;
                     rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err   <= parity_bad_r;
`endif
                     state_r      <= IDLE;
                     s_r          <= SW'(0);
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               s_r     <= SW'(0);
            end
         endcase
      end
   end

endmodule
